// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the sync_fifo_param family.
//   ptr_w(depth) : address width for a DEPTH-entry array
//   cnt_w(depth) : occupancy/pointer width (one wrap bit above the address)
//   count_t      : occupancy type for the default 16-entry configuration
//   fifo_mode_e  : read-port mode (FIFO_STD registered read, FIFO_FWFT fall-through)
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_DEPTH = 16;

  typedef logic [cnt_w(DEF_DEPTH)-1:0] count_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH storage, one synchronous write port, one
// asynchronous (combinational) read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem import fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parameterised FIFO with optional
// first-word-fall-through read port, fill count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Optional build macro FIFO_HWM_EN adds a high-water-mark register on hwm;
// without it hwm is tied to 0.
// Ports:
//   clk, res      : clock (rising edge), async active-high reset
//   wr_en, wdata  : write request / data (ignored while full)
//   rd_en         : pop request (ignored while empty)
//   flag_clr      : clears over_flow/under_flow (and reloads hwm)
//   rdata, rvalid : read data and its qualifier
//   full, empty, almost_full, almost_empty, count : occupancy status
//   over_flow, under_flow : sticky rejected-write / rejected-read flags
//   hwm           : high-water mark
module sync_fifo_param import fifo_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = ptr_w(DEPTH),
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  input  logic                 flag_clr,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rvalid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count,
  output logic                 over_flow,
  output logic                 under_flow,
  output logic [PTR_WIDTH:0]   hwm
);

  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [PTR_WIDTH:0] ONE   = 1;
  localparam logic [PTR_WIDTH:0] DEP_C = DEPTH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AF_C  = AFULL_TH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AE_C  = AEMPTY_TH[PTR_WIDTH:0];

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PTR_WIDTH != $clog2(DEPTH) ||
      AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH > DEPTH ||
      WIDTH < 1 || (FWFT != 0 && FWFT != 1)) begin : g_bad_cfg
    $fatal(1, "sync_fifo_param: illegal parameter set");
  end

  logic [PTR_WIDTH:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, cnt;
  logic               wr_acc, rd_acc;
  logic [WIDTH-1:0]   mem_rdata;

  // Occupancy is the pointer difference; the extra wrap bit disambiguates
  // full (DEPTH) from empty (0). Only registered pointers feed it, so no
  // flag has a combinational path from the request inputs.
  assign cnt          = wr_ptr - rd_ptr;
  assign count        = cnt;
  assign full         = (cnt == DEP_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  assign wr_acc     = wr_en & ~full;
  assign rd_acc     = rd_en & ~empty;
  assign wr_ptr_nxt = wr_acc ? wr_ptr + ONE : wr_ptr;
  assign rd_ptr_nxt = rd_acc ? rd_ptr + ONE : rd_ptr;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      over_flow  <= 1'b0;
      under_flow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      // a new rejection in the clearing cycle keeps the flag set
      over_flow  <= (over_flow  & ~flag_clr) | (wr_en & full);
      under_flow <= (under_flow & ~flag_clr) | (rd_en & empty);
    end
  end

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_WIDTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[PTR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[PTR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    // head word is always presented; rd_en only advances the pointer
    assign rdata  = mem_rdata;
    assign rvalid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    always_ff @(posedge clk or posedge res) begin
      if (res) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem_rdata;
      end
    end
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

`ifdef FIFO_HWM_EN
  logic [PTR_WIDTH:0] cnt_nxt, hwm_q;
  assign cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;
  always_ff @(posedge clk or posedge res) begin
    if (res)                hwm_q <= '0;
    else if (flag_clr)      hwm_q <= cnt;
    else if (cnt_nxt > hwm_q) hwm_q <= cnt_nxt;
  end
  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  localparam int W = 8, D = 16, PW = 4, AF = D - 2, AE = 2;

  logic clk = 1'b0;
  logic res, wr_en, rd_en, flag_clr;
  logic [W-1:0] wdata;

  logic [W-1:0] s_rdata, f_rdata;
  logic s_rvalid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic f_rvalid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [PW:0] s_count, f_count, s_hwm, f_hwm;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .flag_clr(flag_clr), .rdata(s_rdata), .rvalid(s_rvalid), .full(s_full),
    .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .over_flow(s_ovf), .under_flow(s_udf), .hwm(s_hwm));

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .res(res), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .flag_clr(flag_clr), .rdata(f_rdata), .rvalid(f_rvalid), .full(f_full),
    .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .over_flow(f_ovf), .under_flow(f_udf), .hwm(f_hwm));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // reference model: plain queue of stored words plus sticky bits
  logic [W-1:0] q[$];
  bit           m_ovf, m_udf, m_rvalid;
  logic [W-1:0] m_rdata;
  int           m_hwm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_rvalid = 0; m_rdata = '0; m_hwm = 0;
  endtask

  task automatic compare();
    int n;
    n = q.size();
    chk("s_count", s_count, n);        chk("f_count", f_count, n);
    chk("s_full", s_full, n == D);     chk("f_full", f_full, n == D);
    chk("s_empty", s_empty, n == 0);   chk("f_empty", f_empty, n == 0);
    chk("s_afull", s_af, n >= AF);     chk("f_afull", f_af, n >= AF);
    chk("s_aempty", s_ae, n <= AE);    chk("f_aempty", f_ae, n <= AE);
    chk("s_ovf", s_ovf, m_ovf);        chk("f_ovf", f_ovf, m_ovf);
    chk("s_udf", s_udf, m_udf);        chk("f_udf", f_udf, m_udf);
    chk("s_rvalid", s_rvalid, m_rvalid);
    chk("s_rdata", s_rdata, m_rdata);
    chk("f_rvalid", f_rvalid, n != 0);
    if (n != 0) chk("f_rdata", f_rdata, q[0]);
`ifdef FIFO_HWM_EN
    chk("s_hwm", s_hwm, m_hwm);        chk("f_hwm", f_hwm, m_hwm);
`else
    chk("s_hwm", s_hwm, 0);            chk("f_hwm", f_hwm, 0);
`endif
  endtask

  // one clock: drive at negedge, update model at posedge, compare at next negedge
  task automatic step(input bit w, input bit r, input logic [W-1:0] d, input bit c);
    int n;
    bit was_full, was_empty;
    wr_en = w; rd_en = r; wdata = d; flag_clr = c;
    @(posedge clk);
    n = q.size();
    was_full = (n == D); was_empty = (n == 0);
    if (r && !was_empty) begin
      m_rdata = q.pop_front();
      m_rvalid = 1;
    end else m_rvalid = 0;
    if (w && !was_full) q.push_back(d);
    if (c) begin m_ovf = 0; m_udf = 0; end
    if (w && was_full) m_ovf = 1;
    if (r && was_empty) m_udf = 1;
    if (c) m_hwm = n;
    else if (q.size() > m_hwm) m_hwm = q.size();
    @(negedge clk);
    wr_en = 0; rd_en = 0; flag_clr = 0;
    compare();
  endtask

  task automatic do_reset();
    wr_en = 0; rd_en = 0; flag_clr = 0; wdata = '0;
    res = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    res = 0;
    @(negedge clk);
    compare();
  endtask

  initial begin
    res = 1; wr_en = 0; rd_en = 0; flag_clr = 0; wdata = '0;
    do_reset();
    chk("lit_rst_count", s_count, 0);
    chk("lit_rst_empty", s_empty, 1);
    chk("lit_rst_aempty", s_ae, 1);
    chk("lit_rst_rdata", s_rdata, 0);
    chk("lit_rst_rvalid", s_rvalid, 0);

    // fill to full, then one rejected write
    for (int i = 0; i < D; i++) begin
      step(1, 0, W'(i), 0);
      if (i == AF - 2) chk("lit_afull_13", s_af, 0);
      if (i == AF - 1) chk("lit_afull_14", s_af, 1);
    end
    chk("lit_full", s_full, 1);
    chk("lit_count16", s_count, 16);
    step(1, 0, 8'h10, 0);
    chk("lit_ovf", s_ovf, 1);
    chk("lit_count_still16", s_count, 16);
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < D; i++) begin
      step(0, 1, 8'h00, 0);
      chk("lit_rvalid", s_rvalid, 1);
      chk("lit_rdata", s_rdata, i);
    end
    step(0, 0, 8'h00, 0);
    chk("lit_rvalid_idle", s_rvalid, 0);

    // pointer wrap at constant occupancy
    for (int i = 0; i < 3; i++) step(1, 0, W'(8'hA0 + i), 0);
    for (int i = 0; i < 24; i++) step(1, 1, W'($urandom), 0);
    chk("lit_wrap_count", s_count, 3);
    chk("lit_wrap_ovf", s_ovf, 0);
    chk("lit_wrap_udf", s_udf, 0);

    // simultaneous requests at full and at empty
    while (q.size() < D) step(1, 0, W'($urandom), 0);
    step(1, 1, 8'h55, 0);
    chk("lit_full_rw_count", s_count, 15);
    chk("lit_full_rw_ovf", s_ovf, 1);
    while (q.size() > 0) step(0, 1, 8'h00, 0);
    step(1, 1, 8'h66, 0);
    chk("lit_empty_rw_count", s_count, 1);
    chk("lit_empty_rw_udf", s_udf, 1);
    step(0, 0, 8'h00, 1);
    chk("lit_clr_ovf", s_ovf, 0);
    chk("lit_clr_udf", s_udf, 0);

    // fall-through presentation
    do_reset();
    step(1, 0, 8'hA5, 0);
    chk("lit_fwft_rvalid", f_rvalid, 1);
    chk("lit_fwft_rdata", f_rdata, 8'hA5);
    step(0, 1, 8'h00, 0);
    chk("lit_fwft_empty", f_empty, 1);

    // high-water mark
    do_reset();
    for (int i = 0; i < 11; i++) step(1, 0, W'($urandom), 0);
    for (int i = 0; i < 9; i++) step(0, 1, 8'h00, 0);
`ifdef FIFO_HWM_EN
    chk("lit_hwm11", s_hwm, 11);
`else
    chk("lit_hwm_tied", s_hwm, 0);
`endif
    step(0, 0, 8'h00, 1);
`ifdef FIFO_HWM_EN
    chk("lit_hwm_clr", s_hwm, 2);
`endif

    // randomised phases biased toward filling and draining
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 50; i++) begin
        bit w, r, c;
        w = ($urandom_range(0, 99) < ((ph % 2) ? 30 : 75));
        r = ($urandom_range(0, 99) < ((ph % 2) ? 75 : 30));
        c = ($urandom_range(0, 99) < 4);
        step(w, r, W'($urandom), c);
      end
    end

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) step(1, 0, W'($urandom), 0);
    wr_en = 1; wdata = 8'h77;
    #2 res = 1;
    #1;
    chk("lit_async_count", s_count, 0);
    chk("lit_async_fcount", f_count, 0);
    chk("lit_async_hwm", s_hwm, 0);
    chk("lit_async_empty", s_empty, 1);
    chk("lit_async_rvalid", s_rvalid, 0);
    wr_en = 0;
    model_reset();
    @(negedge clk);
    res = 0;
    @(negedge clk);
    compare();
    for (int i = 0; i < 20; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, W'($urandom), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised successor to the team's FIFO. Generalised width/depth with a first-word-fall-through (FWFT) mode option. Adds a fill count, programmable almost-full/almost-empty thresholds and clearable sticky overflow/underflow flags. Used as the generic buffering element inside a single clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
PTR_WIDTH, $clog2(DEPTH), address width; derived, never overridden
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  single clock, rising edge
res  in  1  asynchronous, active-high reset
wr_en  in  1  write request
wdata  in  WIDTH  write data
rd_en  in  1  read (pop) request
flag_clr  in  1  synchronous clear of over_flow/under_flow (and hwm when enabled)
rdata  out  WIDTH  read data
rvalid  out  1  rdata valid qualifier
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_TH
almost_empty  out  1  count <= AEMPTY_TH
count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
over_flow  out  1  sticky: write rejected
under_flow  out  1  sticky: read rejected
hwm  out  PTR_WIDTH+1  high-water mark (FIFO_HWM_EN only; tied 0 otherwise)

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, rdata=0, rvalid=0, empty=1, almost_empty=1, full=0, almost_full=0, over_flow=0, under_flow=0, hwm=0. Memory array not cleared. Reset mid-operation discards all contents.
- Pointers are PTR_WIDTH+1 bits; MSB is the wrap bit; address = low PTR_WIDTH bits; natural wrap at DEPTH.
- wr_acc = wr_en & !full; rd_acc = rd_en & !empty, both evaluated on pre-edge state.
- On wr_acc: mem[wr_ptr] <= wdata; wr_ptr++.
- On rd_acc: rd_ptr++.
- count: +1 on write only, -1 on read only, unchanged when both or neither.
- Status flags are decoded from registered count and change on the same edge as count. There is no combinational path from wr_en/rd_en to any flag.
- Full + wr_en + rd_en: read accepted, write rejected, over_flow set.
- Empty + wr_en + rd_en: write accepted, read rejected, under_flow set.
- over_flow sets on wr_en & full; under_flow sets on rd_en & empty. Both stay set until flag_clr. Set wins over flag_clr in the same cycle.
- FWFT=0: on rd_acc, rdata <= mem[rd_ptr] and rvalid <= 1; otherwise rvalid <= 0 and rdata holds. Read latency is 1 cycle.
- FWFT=1: rdata = mem[rd_ptr] continuously; rvalid = !empty; rd_en pops the head. A written word appears on rdata the cycle after its write edge. rdata is don't-care while empty.
- Elaboration check (fatal): DEPTH power of two, 0 <= AEMPTY_TH < AFULL_TH <= DEPTH.

Optional Feature:
FIFO_HWM_EN
- Defined: hwm register tracks the maximum count reached; it updates to next count whenever next count > hwm. flag_clr loads hwm with the current count. Reset value 0.
- Undefined: no register is built and hwm is tied to 0.

Decomposition:
- Package fifo_pkg: localparam helpers (ptr/count width functions), typedef for count type, FWFT mode enum (FIFO_STD, FIFO_FWFT).
- One sub-module: fifo_mem (1-write/1-read storage array, WIDTH x DEPTH, synchronous write, asynchronous read port). Pointers, flags and read-register stage stay in sync_fifo_param.

Test Plan:
- Reset then idle -> empty=1, almost_empty=1, count=0, rdata=0, rvalid=0, all sticky flags 0.
- FWFT=0, write 16 words 0x00..0x0F, then 17th write -> full=1 at count=16, almost_full=1 from count=14, over_flow=1, 17th word dropped. Read 16 words -> data 0x00..0x0F, each with rvalid one cycle after rd_en.
- Wrap-around: 24 interleaved write/read pairs at count=3 -> count stays 3, data order preserved across the pointer wrap, no flags set.
- Simultaneous requests at full -> count 16->15, over_flow=1. At empty -> count 0->1, under_flow=1. Then flag_clr -> both flags clear.
- FWFT=1: write 0xA5 -> next cycle rvalid=1, rdata=0xA5 with no rd_en. rd_en -> empty=1 next cycle.
- With FIFO_HWM_EN: fill to 11, drain to 2 -> hwm=11. flag_clr -> hwm=2. Assert res mid-burst -> hwm=0, count=0 immediately (async).
